// File: rtl/plp_fetch_pkg.sv
// rtl/plp_fetch_pkg.sv - shared types and constants for the ROM fetch prefetch stage
package plp_fetch_pkg;

    localparam int ROM_AW = 9;
    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry fetch FIFO with flush, count and registered head
module fetch_fifo
    import plp_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr_n;
    logic [CW-1:0]  count_n;
    fetch_entry_t   head_n;

    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + 1'b1;
        end else if (!push && pop) begin
            count_n = count - 1'b1;
        end
        rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
        // Head register tracks the entry at the next read pointer; an entry pushed
        // into an otherwise-empty queue goes straight to the head.
        head_n = head;
        if (count_n != '0) begin
            if (push && (count == CW'(pop))) begin
                head_n = push_data;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_n;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count      <= count_n;
            head       <= head_n;
            head_valid <= (count_n != '0);
        end
    end

endmodule

// File: rtl/rom_fetch_prefetch.sv
// rtl/rom_fetch_prefetch.sv - sequential ROM prefetch with redirect flush; ROM_FETCH_BYPASS_EN adds empty-FIFO bypass
module rom_fetch_prefetch
    import plp_fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] inflight_pc;
    logic              inflight;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    fetch_entry_t      ret_entry;
    logic              head_valid;
    logic              push;
    logic              pop;

    // Credit covers the word still in flight so a return always has a free slot.
    assign rom_en    = !redirect && ((int'(count) + int'(inflight)) < DEPTH);
    assign rom_addr  = fetch_pc[ROM_AW+1:2];
    assign ret_entry = '{pc: inflight_pc, instr: rom_data};
    assign pop       = head_valid && instr_ready;

`ifdef ROM_FETCH_BYPASS_EN
    logic bypass;
    assign bypass      = inflight && !head_valid;
    assign instr_valid = head_valid || bypass;
    assign instr       = bypass ? rom_data : head.instr;
    assign instr_pc    = bypass ? inflight_pc : head.pc;
    assign push        = inflight && !redirect && !(bypass && instr_ready);
`else
    assign instr_valid = head_valid;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign push        = inflight && !redirect;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[WORD_W-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= rom_en;
            if (rom_en) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_data  (ret_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

endmodule
